// File: rtl/nvdla_dmaif_rd_router.sv
// RDMA read router: steers client requests to NPORT memory ports and
// merges the responses back in request order, one burst at a time.
module nvdla_dmaif_rd_router #(
  parameter int NPORT      = 2,
  parameter int PORT_W     = 1,
  parameter int REQ_W      = 79,
  parameter int SIZE_LSB   = 64,
  parameter int SIZE_W     = 15,
  parameter int RSP_W      = 514,
  parameter int OUTS_DEPTH = 32
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic [REQ_W-1:0]         dma_rd_req_pd,
  input  logic [PORT_W-1:0]        dma_rd_req_port,
  input  logic                     dma_rd_req_vld,
  output logic                     dma_rd_req_rdy,
  output logic [RSP_W-1:0]         dma_rd_rsp_pd,
  output logic                     dma_rd_rsp_vld,
  input  logic                     dma_rd_rsp_rdy,
  input  logic                     dma_rd_cdt_lat_fifo_pop,
  input  logic [PORT_W-1:0]        dma_rd_cdt_port,
  output logic [NPORT*REQ_W-1:0]   port_rd_req_pd,
  output logic [NPORT-1:0]         port_rd_req_valid,
  input  logic [NPORT-1:0]         port_rd_req_ready,
  input  logic [NPORT*RSP_W-1:0]   port_rd_rsp_pd,
  input  logic [NPORT-1:0]         port_rd_rsp_valid,
  output logic [NPORT-1:0]         port_rd_rsp_ready,
  output logic [NPORT-1:0]         port_rd_cdt_lat_fifo_pop,
  output logic [$clog2(OUTS_DEPTH+1)-1:0] outs_cnt,
  output logic                     err_bad_port,
  output logic                     err_unexp_rsp
);

  localparam int CNT_W = $clog2(OUTS_DEPTH+1);
  localparam int AW    = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int ENT_W = PORT_W + SIZE_W;

  logic               req_q_vld;
  logic [REQ_W-1:0]   req_q_pd;
  logic [PORT_W-1:0]  req_q_port;
  logic               port_ok;
  logic               req_hs;
  logic               req_drain;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_ne;
  logic [ENT_W-1:0]   fifo_mem [OUTS_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [PORT_W-1:0]  head_port;
  logic [SIZE_W-1:0]  head_size;
  logic [SIZE_W-1:0]  beat_cnt;
  logic               rsp_en;
  logic               rsp_hs;
  logic [RSP_W-1:0]   rsp_sel;

  assign port_ok   = 32'(dma_rd_req_port) < NPORT;
  assign fifo_full = outs_cnt == CNT_W'(OUTS_DEPTH);
  assign fifo_ne   = outs_cnt != '0;
  assign req_drain = |(port_rd_req_valid & port_rd_req_ready);
  assign dma_rd_req_rdy = (!req_q_vld | req_drain) & !fifo_full;
  assign req_hs    = dma_rd_req_vld & dma_rd_req_rdy;
  assign push      = req_hs & port_ok;

  assign port_rd_req_pd = {NPORT{req_q_pd}};

  always_comb begin
    port_rd_req_valid = '0;
    for (int i = 0; i < NPORT; i++)
      port_rd_req_valid[i] = req_q_vld && (32'(req_q_port) == i);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      req_q_vld  <= 1'b0;
      req_q_pd   <= '0;
      req_q_port <= '0;
    end else if (push) begin
      req_q_vld  <= 1'b1;
      req_q_pd   <= dma_rd_req_pd;
      req_q_port <= dma_rd_req_port;
    end else if (req_drain) begin
      req_q_vld  <= 1'b0;
    end
  end

  // Order FIFO of {port, size}; storage needs no reset, pointers do
  always_ff @(posedge nvdla_core_clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {dma_rd_req_port, dma_rd_req_pd[SIZE_LSB +: SIZE_W]};
  end

  assign {head_port, head_size} = fifo_mem[rd_ptr];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      outs_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == AW'(OUTS_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(OUTS_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      unique case (1'b1)
        push & !pop: outs_cnt <= outs_cnt + 1'b1;
        pop & !push: outs_cnt <= outs_cnt - 1'b1;
        default:     outs_cnt <= outs_cnt;
      endcase
    end
  end

  assign rsp_en = fifo_ne & (!dma_rd_rsp_vld | dma_rd_rsp_rdy);

  always_comb begin
    port_rd_rsp_ready = '0;
    rsp_sel = '0;
    for (int i = 0; i < NPORT; i++) begin
      port_rd_rsp_ready[i] = rsp_en && (32'(head_port) == i);
      if (32'(head_port) == i)
        rsp_sel = port_rd_rsp_pd[i*RSP_W +: RSP_W];
    end
  end

  assign rsp_hs = |(port_rd_rsp_ready & port_rd_rsp_valid);
  assign pop    = rsp_hs & (beat_cnt == head_size);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dma_rd_rsp_vld <= 1'b0;
      dma_rd_rsp_pd  <= '0;
      beat_cnt       <= '0;
    end else if (rsp_hs) begin
      dma_rd_rsp_vld <= 1'b1;
      dma_rd_rsp_pd  <= rsp_sel;
      beat_cnt       <= pop ? '0 : beat_cnt + 1'b1;
    end else if (dma_rd_rsp_rdy) begin
      dma_rd_rsp_vld <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      port_rd_cdt_lat_fifo_pop <= '0;
      err_bad_port  <= 1'b0;
      err_unexp_rsp <= 1'b0;
    end else begin
      for (int i = 0; i < NPORT; i++)
        port_rd_cdt_lat_fifo_pop[i] <= dma_rd_cdt_lat_fifo_pop
                                       && (32'(dma_rd_cdt_port) == i);
      if (req_hs && !port_ok)
        err_bad_port <= 1'b1;
      if ((|port_rd_rsp_valid) && !fifo_ne)
        err_unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nvdla_dmaif_rd_router.sv
// Directed bench for nvdla_dmaif_rd_router: ordering, full, backpressure,
// error flags, credit pops and reset.
module tb_nvdla_dmaif_rd_router;

  localparam int NPORT = 2;
  localparam int PW    = 2;
  localparam int REQ_W = 79;
  localparam int RSP_W = 514;

  logic                   clk;
  logic                   rst_n;
  logic [REQ_W-1:0]       req_pd;
  logic [PW-1:0]          req_port;
  logic                   req_vld;
  logic                   req_rdy;
  logic [RSP_W-1:0]       rsp_pd;
  logic                   rsp_vld;
  logic                   rsp_rdy;
  logic                   cdt_pop;
  logic [PW-1:0]          cdt_port;
  logic [NPORT*REQ_W-1:0] p_req_pd;
  logic [NPORT-1:0]       p_req_valid;
  logic [NPORT-1:0]       p_req_ready;
  logic [NPORT*RSP_W-1:0] p_rsp_pd;
  logic [NPORT-1:0]       p_rsp_valid;
  logic [NPORT-1:0]       p_rsp_ready;
  logic [NPORT-1:0]       p_cdt_pop;
  logic [5:0]             outs_cnt;
  logic                   err_bad_port;
  logic                   err_unexp_rsp;

  int n_chk;
  int n_fail;

  nvdla_dmaif_rd_router #(.NPORT(NPORT), .PORT_W(PW)) dut (
    .nvdla_core_clk           (clk),
    .nvdla_core_rstn          (rst_n),
    .dma_rd_req_pd            (req_pd),
    .dma_rd_req_port          (req_port),
    .dma_rd_req_vld           (req_vld),
    .dma_rd_req_rdy           (req_rdy),
    .dma_rd_rsp_pd            (rsp_pd),
    .dma_rd_rsp_vld           (rsp_vld),
    .dma_rd_rsp_rdy           (rsp_rdy),
    .dma_rd_cdt_lat_fifo_pop  (cdt_pop),
    .dma_rd_cdt_port          (cdt_port),
    .port_rd_req_pd           (p_req_pd),
    .port_rd_req_valid        (p_req_valid),
    .port_rd_req_ready        (p_req_ready),
    .port_rd_rsp_pd           (p_rsp_pd),
    .port_rd_rsp_valid        (p_rsp_valid),
    .port_rd_rsp_ready        (p_rsp_ready),
    .port_rd_cdt_lat_fifo_pop (p_cdt_pop),
    .outs_cnt                 (outs_cnt),
    .err_bad_port             (err_bad_port),
    .err_unexp_rsp            (err_unexp_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REQ_W-1:0] mkreq(input logic [63:0] a,
                                             input logic [14:0] s);
    logic [REQ_W-1:0] r;
    r = '0;
    r[63:0]  = a;
    r[78:64] = s;
    return r;
  endfunction

  task automatic set_rsp(input int p, input logic [63:0] v);
    p_rsp_pd[p*RSP_W +: RSP_W] = {{(RSP_W-64){1'b0}}, v};
  endtask

  task automatic send_req(input int p, input logic [63:0] a,
                          input logic [14:0] s);
    req_vld  = 1'b1;
    req_port = PW'(p);
    req_pd   = mkreq(a, s);
    tick();
    req_vld  = 1'b0;
  endtask

  initial begin
    int sent;
    int got;
    logic [63:0] sl;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_pd = '0; req_port = '0; req_vld = 1'b0;
    rsp_rdy = 1'b1; cdt_pop = 1'b0; cdt_port = '0;
    p_req_ready = 2'b11; p_rsp_pd = '0; p_rsp_valid = '0;
    tick();
    tick();
    check("rst_req_valid", 64'(p_req_valid), 0);
    check("rst_rsp_vld", 64'(rsp_vld), 0);
    check("rst_outs_cnt", 64'(outs_cnt), 0);
    check("rst_errs", 64'({err_bad_port, err_unexp_rsp}), 0);
    check("rst_cdt", 64'(p_cdt_pop), 0);
    rst_n = 1'b1;
    tick();

    // single request, port 1, size 0
    req_vld = 1'b1; req_port = 2'd1; req_pd = mkreq(64'h1000, 0);
    #1;
    check("t1_rdy", 64'(req_rdy), 1);
    tick();
    req_vld = 1'b0;
    check("t1_req_valid", 64'(p_req_valid), 64'b10);
    sl = p_req_pd[REQ_W +: 64];
    check("t1_req_addr", sl, 64'h1000);
    check("t1_outs1", 64'(outs_cnt), 1);
    p_rsp_valid = 2'b10;
    p_rsp_pd[RSP_W +: RSP_W] = {9{64'hA5A5_A5A5_A5A5_A5A5}};
    #1;
    check("t1_rsp_ready", 64'(p_rsp_ready), 64'b10);
    tick();
    p_rsp_valid = '0;
    check("t1_rsp_vld", 64'(rsp_vld), 1);
    check("t1_rsp_pd", rsp_pd[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
    check("t1_outs0", 64'(outs_cnt), 0);
    check("t1_req_drop", 64'(p_req_valid), 0);
    tick();
    check("t1_rsp_done", 64'(rsp_vld), 0);

    // ordering: port0 x4 beats then port1, port1 responds first
    send_req(0, 64'h2000, 3);
    send_req(1, 64'h3000, 0);
    check("t2_outs2", 64'(outs_cnt), 2);
    p_rsp_valid = 2'b10;
    set_rsp(1, 64'hB1);
    tick();
    tick();
    check("t2_p1_held", 64'(p_rsp_ready), 64'b01);
    check("t2_no_rsp", 64'(rsp_vld), 0);
    for (int k = 0; k < 4; k++) begin
      p_rsp_valid = 2'b11;
      set_rsp(0, 64'hC0 + 64'(k));
      #1;
      check("t2_p0_grant", 64'(p_rsp_ready), 64'b01);
      tick();
      check("t2_p0_beat", rsp_pd[63:0], 64'hC0 + 64'(k));
    end
    p_rsp_valid = 2'b10;
    #1;
    check("t2_p1_grant", 64'(p_rsp_ready), 64'b10);
    tick();
    p_rsp_valid = '0;
    check("t2_p1_beat", rsp_pd[63:0], 64'hB1);
    check("t2_outs0", 64'(outs_cnt), 0);
    tick();

    // backpressure mid-burst, 6 beats, client stalls 5 cycles
    send_req(0, 64'h4000, 5);
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      rsp_rdy = !(c >= 3 && c < 8);
      p_rsp_valid = (sent < 6) ? 2'b01 : 2'b00;
      set_rsp(0, 64'hD0 + 64'(sent));
      #1;
      if (rsp_vld && rsp_rdy) begin
        check("t3_beat", rsp_pd[63:0], 64'hD0 + 64'(got));
        got++;
      end
      if (p_rsp_valid[0] && p_rsp_ready[0])
        sent++;
      tick();
    end
    p_rsp_valid = '0;
    rsp_rdy = 1'b1;
    check("t3_count", 64'(got), 6);
    check("t3_outs0", 64'(outs_cnt), 0);
    check("t3_idle", 64'(rsp_vld), 0);

    // bad port and unexpected response
    req_vld = 1'b1; req_port = 2'd3; req_pd = mkreq(64'h5000, 0);
    #1;
    check("t4_rdy", 64'(req_rdy), 1);
    tick();
    req_vld = 1'b0;
    check("t4_no_valid", 64'(p_req_valid), 0);
    check("t4_err_bad", 64'(err_bad_port), 1);
    check("t4_outs0", 64'(outs_cnt), 0);
    check("t4_unexp_clr", 64'(err_unexp_rsp), 0);
    p_rsp_valid = 2'b01;
    tick();
    p_rsp_valid = '0;
    check("t4_err_unexp", 64'(err_unexp_rsp), 1);

    // credit pops
    cdt_pop = 1'b1; cdt_port = 2'd0;
    tick();
    check("t5_pop0", 64'(p_cdt_pop), 64'b01);
    cdt_port = 2'd1;
    tick();
    check("t5_pop1", 64'(p_cdt_pop), 64'b10);
    cdt_port = 2'd3;
    tick();
    check("t5_pop_bad", 64'(p_cdt_pop), 0);
    cdt_pop = 1'b0;
    tick();

    // fill the order FIFO
    sent = 0;
    for (int k = 0; k < 32; k++) begin
      req_vld = 1'b1; req_port = 2'd0; req_pd = mkreq(64'(k), 0);
      #1;
      if (req_rdy) sent++;
      tick();
    end
    check("t6_accepted", 64'(sent), 32);
    check("t6_outs32", 64'(outs_cnt), 32);
    check("t6_rdy_low", 64'(req_rdy), 0);
    p_rsp_valid = 2'b01;
    set_rsp(0, 64'hE0);
    #1;
    check("t6_pop_push_rdy", 64'(req_rdy), 0);
    tick();
    p_rsp_valid = '0;
    check("t6_outs31", 64'(outs_cnt), 31);
    check("t6_rdy_back", 64'(req_rdy), 1);
    tick();
    req_vld = 1'b0;
    check("t6_outs32b", 64'(outs_cnt), 32);

    // reset mid-burst
    p_rsp_valid = 2'b01;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    p_rsp_valid = '0;
    #1;
    check("t7_rsp_vld", 64'(rsp_vld), 0);
    check("t7_outs", 64'(outs_cnt), 0);
    check("t7_req_valid", 64'(p_req_valid), 0);
    check("t7_rsp_ready", 64'(p_rsp_ready), 0);
    check("t7_errs", 64'({err_bad_port, err_unexp_rsp}), 0);
    check("t7_rsp_pd", rsp_pd[63:0], 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_rdy", 64'(req_rdy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
